// File: rtl/freq_meter.sv
// freq_meter: measures the period of a slow asynchronous input in system
// clock cycles. Each completed period is reported on period_out together
// with a one-cycle valid strobe. A missing edge within MAX_PERIOD cycles
// produces a one-cycle timeout strobe, and the block then re-arms.
// Optional build macro FREQ_METER_LOCK_CHECK_EN enables the frequency-lock
// flag. When the macro is undefined, lock is tied to 0.
module freq_meter #(
  parameter int CNT_W           = 16,
  parameter int MAX_PERIOD      = 65535,
  parameter int EXPECTED_PERIOD = 1000,
  parameter int TOLERANCE       = 2,
  parameter int LOCK_COUNT      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             busy,
  output logic             timeout,
  output logic             lock
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // The counter stays below MAX_PERIOD, so cnt_q + 1 cannot overflow CNT_W.
  assign rise_s    = sync2_q & ~sync3_q;
  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Next-state logic: arm on en, measure between edges, time out on missing edges.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (en) begin
          state_d = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        // The first edge only starts the count; it never reports a period.
        cnt_d = {CNT_W{1'b0}};
        if (!en) begin
          state_d = S_IDLE;
        end else if (rise_s) begin
          state_d = S_MEASURE;
        end else begin
          state_d = S_ARM;
        end
      end
      S_MEASURE: begin
        if (!en) begin
          // en wins over a coincident edge: the partial period is dropped.
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (rise_s) begin
          // An edge wins over a coincident timeout, so period_out can equal MAX_PERIOD.
          period_d = cnt_inc_s;
          valid_d  = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
        end else if (cnt_inc_s == MAX_P) begin
          timeout_d = 1'b1;
          state_d   = S_ARM;
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and the registered result/strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      period_q  <= {CNT_W{1'b0}};
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_out = period_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != S_IDLE);

`ifdef FREQ_METER_LOCK_CHECK_EN
  localparam int LC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_COUNT);
  localparam int LO_P = EXPECTED_PERIOD - TOLERANCE;
  localparam int HI_P = EXPECTED_PERIOD + TOLERANCE;

  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            lock_q, lock_d;
  logic            in_range_s;

  assign in_range_s = (int'(cnt_inc_s) >= LO_P) && (int'(cnt_inc_s) <= HI_P);

  // Lock counter: counts consecutive in-tolerance periods and saturates at LOCK_COUNT.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    if (!en || timeout_d) begin
      lock_cnt_d = {LC_W{1'b0}};
      lock_d     = 1'b0;
    end else if (valid_d) begin
      if (in_range_s) begin
        if (lock_cnt_q != LOCK_MAX) begin
          lock_cnt_d = lock_cnt_q + {{(LC_W-1){1'b0}}, 1'b1};
        end else begin
          lock_cnt_d = lock_cnt_q;
        end
        lock_d = (lock_cnt_d == LOCK_MAX);
      end else begin
        lock_cnt_d = {LC_W{1'b0}};
        lock_d     = 1'b0;
      end
    end else begin
      lock_cnt_d = lock_cnt_q;
      lock_d     = lock_q;
    end
  end

  // Lock registers update in the same edge as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= {LC_W{1'b0}};
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  localparam int unused_lock_cfg = EXPECTED_PERIOD + TOLERANCE + LOCK_COUNT;
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed testbench for freq_meter (MAX_PERIOD = 2000). Valid and timeout
// events are logged with their cycle number at the falling edge. The
// stimulus sequence compares the logs and the outputs against
// hand-computed values.
module tb_freq_meter;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic        sig_in = 1'b0;
  logic [15:0] period_out;
  logic        valid, busy, timeout, lock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int overlap = 0;
  int v_cyc[$];
  int v_per[$];
  int t_cyc[$];
  int exp_p[$];
  logic v_lock[$];
  logic exp_l[$];

  freq_meter #(
    .CNT_W(16), .MAX_PERIOD(2000), .EXPECTED_PERIOD(1000),
    .TOLERANCE(2), .LOCK_COUNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .period_out(period_out), .valid(valid), .busy(busy),
    .timeout(timeout), .lock(lock)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // event log, sampled on the falling edge
  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_per.push_back(int'(period_out));
      v_lock.push_back(lock);
    end
    if (timeout) t_cyc.push_back(cyc);
    if (valid && timeout) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic train(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      tick(p / 2);
      sig_in = 1'b0;
      tick(p - p / 2);
    end
  endtask

  task automatic clear_logs();
    v_cyc.delete();
    v_per.delete();
    v_lock.delete();
    t_cyc.delete();
  endtask

  task automatic check_train(input string tag, input int first);
    chk($sformatf("%s_count", tag), v_per.size(), exp_p.size());
    for (int i = 0; i < v_per.size() && i < exp_p.size(); i++) begin
      chk($sformatf("%s_per%0d", tag, i), v_per[i], exp_p[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), v_cyc[i] - v_cyc[i-1], exp_p[i]);
    end
    if (v_cyc.size() > 0) chk($sformatf("%s_first", tag), v_cyc[0], first);
  endtask

  initial begin
    int s;
    int lastv;

    // Reset state
    tick(10);
    chk("rst_period", period_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_lock", lock, 0);
    rst_n = 1'b1;
    tick(2);
    en = 1'b1;
    tick(2);
    chk("arm_busy", busy, 1);

    // 1: period 1000, first valid at the 2nd edge
    clear_logs();
    s = cyc;
    train(1000, 5);
    exp_p = {1000, 1000, 1000, 1000};
    check_train("p1000", s + 1003);
    chk("p1000_timeouts", t_cyc.size(), 0);

    // 2: partial period of 700, then period 37
    clear_logs();
    s = cyc;
    sig_in = 1'b1;
    tick(500);
    sig_in = 1'b0;
    tick(200);
    train(37, 5);
    exp_p = {1000, 700, 37, 37, 37, 37};
    check_train("p37", s + 3);

    // 3: input stalls, timeout 2000 cycles after the last valid
    lastv = (v_cyc.size() > 0) ? v_cyc[v_cyc.size()-1] : 0;
    clear_logs();
    tick(2100);
    chk("to_count", t_cyc.size(), 1);
    if (t_cyc.size() > 0) chk("to_cycle", t_cyc[0], lastv + 2000);
    chk("to_no_valid", v_per.size(), 0);
    chk("to_busy", busy, 1);
    chk("to_period_kept", period_out, 37);
    clear_logs();
    s = cyc;
    train(1000, 3);
    exp_p = {1000, 1000};
    check_train("restart", s + 1003);

    // 4a: en dropped 300 cycles into a period
    clear_logs();
    sig_in = 1'b1;
    tick(303);
    en = 1'b0;
    tick(1);
    chk("en_mid_busy", busy, 0);
    tick(20);
    chk("en_mid_valids", v_per.size(), 1);
    chk("en_mid_period", period_out, 1000);

    // 4b: en dropped on the rise cycle
    sig_in = 1'b0;
    tick(10);
    en = 1'b1;
    tick(5);
    clear_logs();
    sig_in = 1'b1;
    tick(500);
    sig_in = 1'b0;
    tick(500);
    sig_in = 1'b1;
    tick(2);
    en = 1'b0;
    tick(1);
    chk("en_rise_busy", busy, 0);
    chk("en_rise_valid", valid, 0);
    tick(20);
    chk("en_rise_valids", v_per.size(), 0);
    chk("en_rise_period", period_out, 1000);
    chk("en_rise_timeouts", t_cyc.size(), 0);

    // 5: asynchronous reset mid-measurement
    sig_in = 1'b0;
    en = 1'b1;
    tick(10);
    sig_in = 1'b1;
    tick(500);
    sig_in = 1'b0;
    tick(100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_period", period_out, 0);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_lock", lock, 0);
    tick(3);
    #2;
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    s = cyc;
    train(1000, 3);
    exp_p = {1000, 1000};
    check_train("post_rst", s + 1003);

    // 6: lock sequence 1000, 1001, 999, 1002, 1010
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(2);
    clear_logs();
    s = cyc;
    train(1000, 1);
    train(1001, 1);
    train(999, 1);
    train(1002, 1);
    train(1010, 1);
    train(20, 1);
    exp_p = {1000, 1001, 999, 1002, 1010};
    check_train("lockseq", s + 1003);
`ifdef FREQ_METER_LOCK_CHECK_EN
    exp_l = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < v_lock.size() && i < exp_l.size(); i++) begin
      chk($sformatf("lock%0d", i), v_lock[i], exp_l[i]);
    end

    chk("valid_timeout_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
